// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/response bundle for the EX-stage ALU.
// The master issues ops and consumes results; the slave is the ALU.
interface multicycle_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [2:0]      btype;
  logic [XLEN-1:0] alu_in_1;
  logic [XLEN-1:0] alu_in_2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            alu_bcond;

  modport master (
    output in_valid, alu_op, btype,
    output alu_in_1, alu_in_2, out_ready,
    input  in_ready, out_valid,
    input  alu_result, alu_bcond
  );

  modport slave (
    input  in_valid, alu_op, btype,
    input  alu_in_1, alu_in_2, out_ready,
    output in_ready, out_valid,
    output alu_result, alu_bcond
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: RV32I ALU/branch compare (1 cycle) plus iterative RV32M.
// Divide/remainder unit is built only when ALU_DIV_EN is defined.
module multicycle_alu #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input logic             clk,
  input logic             reset,
  multicycle_alu_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] low;
  logic [XLEN-1:0] opnd;
  logic            neg_q;
  logic            sel;
  logic [XLEN-1:0] result;
  logic            bcond;
`ifdef ALU_DIV_EN
  logic            neg_r;
  logic            dz;
`endif

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      op;
  logic [2:0]      f3;
  logic            accept;
  logic            is_mul;
  logic            is_div;
  logic            last;

  assign a      = bus.alu_in_1;
  assign b      = bus.alu_in_2;
  assign op     = bus.alu_op;
  assign f3     = op[2:0];
  assign is_mul = op[4] & ~op[2];
`ifdef ALU_DIV_EN
  assign is_div = op[4] & op[2];
`else
  assign is_div = 1'b0;
`endif
  assign last   = (cnt == '1);

  assign bus.in_ready   = (state == IDLE) |
                          ((state == DONE) & bus.out_ready);
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.out_valid  = (state == DONE);
  assign bus.alu_result = result;
  assign bus.alu_bcond  = bcond;

  logic [XLEN-1:0] base_res;
  logic            base_bc;
  logic            lt_s;
  logic            lt_u;
  logic            eq;

  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;
  assign eq   = (a == b);

  // Single-cycle RV32I result and branch condition
  always_comb begin
    base_res = '0;
    base_bc  = 1'b0;
    case (op[3:0])
      4'b0010: base_res = a + b;
      4'b0110: base_res = a - b;
      4'b0000: base_res = a & b;
      4'b0001: base_res = a | b;
      4'b1001: base_res = a ^ b;
      4'b1010: base_res = a << b[SHW-1:0];
      4'b1100: base_res = a >> b[SHW-1:0];
      4'b1101: base_res = $unsigned($signed(a) >>> b[SHW-1:0]);
      4'b0111: base_res = {{(XLEN-1){1'b0}}, lt_s};
      4'b0011: base_res = {{(XLEN-1){1'b0}}, lt_u};
      default: base_res = '0;
    endcase
    if (op[3:0] == 4'b0110) begin
      case (bus.btype)
        3'b000:  base_bc = eq;
        3'b001:  base_bc = ~eq;
        3'b100:  base_bc = lt_s;
        3'b101:  base_bc = ~lt_s;
        3'b110:  base_bc = lt_u;
        3'b111:  base_bc = ~lt_u;
        default: base_bc = 1'b0;
      endcase
    end
  end

  logic            sgn_a;
  logic            sgn_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  // Operand signedness and magnitudes at accept time
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (1'b1)
      op[2]:   begin
        sgn_a = ~f3[0];
        sgn_b = ~f3[0];
      end
      default: begin
        sgn_a = (f3[1:0] != 2'b11);
        sgn_b = ~f3[1];
      end
    endcase
    a_neg = sgn_a & a[XLEN-1];
    b_neg = sgn_b & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_prod;
  logic [2*XLEN-1:0] mul_fix;

  // Shift-add step: acc:low holds partial product and multiplier
  always_comb begin
    mul_add  = low[0] ? opnd : '0;
    mul_sum  = {1'b0, acc} + {1'b0, mul_add};
    mul_prod = {mul_sum, low[XLEN-1:1]};
    mul_fix  = neg_q ? -mul_prod : mul_prod;
  end

`ifdef ALU_DIV_EN
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_r;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  // Restoring step: acc is partial remainder, low shifts out dividend
  always_comb begin
    div_sh   = {acc, low[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ge   = ~div_diff[XLEN];
    div_r    = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    div_q    = {low[XLEN-2:0], div_ge};
    q_fix    = dz ? '1 : (neg_q ? -div_q : div_q);
    r_fix    = neg_r ? -div_r : div_r;
  end
`endif

  // Control FSM and iterative datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      low    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      sel    <= 1'b0;
      result <= '0;
      bcond  <= 1'b0;
`ifdef ALU_DIV_EN
      neg_r  <= 1'b0;
      dz     <= 1'b0;
`endif
    end else begin
      unique case (state)
        MUL: begin
          acc <= mul_sum[XLEN:1];
          low <= {mul_sum[0], low[XLEN-1:1]};
          cnt <= cnt + 1'b1;
          if (last) begin
            state  <= DONE;
            bcond  <= 1'b0;
            result <= sel ? mul_fix[2*XLEN-1:XLEN]
                          : mul_fix[XLEN-1:0];
          end
        end
`ifdef ALU_DIV_EN
        DIV: begin
          acc <= div_r;
          low <= div_q;
          cnt <= cnt + 1'b1;
          if (last) begin
            state  <= DONE;
            bcond  <= 1'b0;
            result <= sel ? r_fix : q_fix;
          end
        end
`endif
        default: begin
          if (accept) begin
            cnt   <= '0;
            acc   <= '0;
            neg_q <= a_neg ^ b_neg;
            if (is_mul) begin
              state <= MUL;
              opnd  <= a_mag;
              low   <= b_mag;
              sel   <= (f3 != 3'b000);
            end else if (is_div) begin
              state <= DIV;
              opnd  <= b_mag;
              low   <= a_mag;
              sel   <= f3[1];
`ifdef ALU_DIV_EN
              neg_r <= a_neg;
              dz    <= (b == '0);
`endif
            end else begin
              state  <= DONE;
              result <= op[4] ? '0 : base_res;
              bcond  <= op[4] ? 1'b0 : base_bc;
            end
          end else if (state == DONE && bus.out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed checks of multicycle_alu, XLEN=32.
// Divide checks are selected by ALU_DIV_EN, matching the DUT build.
module tb_multicycle_alu;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  multicycle_alu_if #(.XLEN(32)) bus ();

  multicycle_alu #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0]  op,
                      input logic [2:0]  bt,
                      input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'(n), 32'd0);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.btype    = bt;
    bus.alu_in_1 = a;
    bus.alu_in_2 = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.alu_in_1 = 32'hDEAD_BEEF;
    bus.alu_in_2 = 32'h1234_5678;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.alu_op   = 5'b0;
    bus.btype    = 3'b0;
    bus.alu_in_1 = 32'h0;
    bus.alu_in_2 = 32'h0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.alu_result, 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);

    // reset aborts a multiply in flight
    send(5'b10000, 3'b000, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    chk("mul_busy_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_result", bus.alu_result, 32'h0);
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) @(negedge clk);
    chk("abort_no_late", 32'(bus.out_valid), 32'd0);

    // back-to-back ADD then SRA
    bus.in_valid = 1'b1;
    bus.alu_op   = 5'b00010;
    bus.btype    = 3'b000;
    bus.alu_in_1 = 32'h7FFF_FFFF;
    bus.alu_in_2 = 32'h1;
    @(negedge clk);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_result", bus.alu_result, 32'h8000_0000);
    chk("add_ready", 32'(bus.in_ready), 32'd1);
    bus.alu_op   = 5'b01101;
    bus.alu_in_1 = 32'h8000_0000;
    bus.alu_in_2 = 32'h4;
    @(negedge clk);
    chk("sra_valid", 32'(bus.out_valid), 32'd1);
    chk("sra_result", bus.alu_result, 32'hF800_0000);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid", 32'(bus.out_valid), 32'd0);

    // branch compares on SUB
    send(5'b00110, 3'b100, 32'h8000_0000, 32'h1);
    chk("blt_ovf", 32'(bus.alu_bcond), 32'd1);
    chk("sub_result", bus.alu_result, 32'h7FFF_FFFF);
    send(5'b00110, 3'b110, 32'h8000_0000, 32'h1);
    chk("bltu", 32'(bus.alu_bcond), 32'd0);
    send(5'b00110, 3'b011, 32'h5, 32'h5);
    chk("btype_011", 32'(bus.alu_bcond), 32'd0);
    send(5'b00110, 3'b000, 32'h5, 32'h5);
    chk("beq", 32'(bus.alu_bcond), 32'd1);
    send(5'b00110, 3'b101, 32'hFFFF_FFFF, 32'h1);
    chk("bge", 32'(bus.alu_bcond), 32'd0);
    send(5'b00010, 3'b000, 32'h5, 32'h5);
    chk("add_nobc", 32'(bus.alu_bcond), 32'd0);

    // other base ops
    send(5'b00111, 3'b000, 32'hFFFF_FFFF, 32'h1);
    chk("slt", bus.alu_result, 32'h1);
    send(5'b00011, 3'b000, 32'hFFFF_FFFF, 32'h1);
    chk("sltu", bus.alu_result, 32'h0);
    send(5'b01010, 3'b000, 32'h1, 32'h0000_003F);
    chk("sll", bus.alu_result, 32'h8000_0000);
    send(5'b01100, 3'b000, 32'h8000_0000, 32'h4);
    chk("srl", bus.alu_result, 32'h0800_0000);
    send(5'b01001, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    chk("xor", bus.alu_result, 32'h0FF0_0FF0);
    send(5'b00100, 3'b000, 32'h1234, 32'h1);
    chk("unknown_op", bus.alu_result, 32'h0);

    // multiplies
    send(5'b10001, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(lat);
    chk("mulh_lat", 32'(lat), 32'd33);
    chk("mulh", bus.alu_result, 32'h0);
    send(5'b10000, 3'b000, 32'hFFFF_FFFF, 32'h7);
    wait_valid(lat);
    chk("mul_lat", 32'(lat), 32'd33);
    chk("mul", bus.alu_result, 32'hFFFF_FFF9);
    send(5'b10010, 3'b000, 32'hFFFF_FFFF, 32'h2);
    wait_valid(lat);
    chk("mulhsu", bus.alu_result, 32'hFFFF_FFFF);
    send(5'b10011, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.out_ready = 1'b0;
    wait_valid(lat);
    chk("mulhu_lat", 32'(lat), 32'd33);
    chk("mulhu", bus.alu_result, 32'hFFFF_FFFE);
    repeat (5) @(negedge clk);
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_result", bus.alu_result, 32'hFFFF_FFFE);
    chk("hold_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("retire_valid", 32'(bus.out_valid), 32'd0);

`ifdef ALU_DIV_EN
    send(5'b10100, 3'b000, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(lat);
    chk("div_lat", 32'(lat), 32'd33);
    chk("div_ovf", bus.alu_result, 32'h8000_0000);
    send(5'b10110, 3'b000, 32'hFFFF_FFF9, 32'h2);
    wait_valid(lat);
    chk("rem_lat", 32'(lat), 32'd33);
    chk("rem_neg", bus.alu_result, 32'hFFFF_FFFF);
    send(5'b10101, 3'b000, 32'h5, 32'h0);
    wait_valid(lat);
    chk("divu0_lat", 32'(lat), 32'd33);
    chk("divu0", bus.alu_result, 32'hFFFF_FFFF);
    send(5'b10110, 3'b000, 32'hFFFF_FFF9, 32'h0);
    wait_valid(lat);
    chk("rem0", bus.alu_result, 32'hFFFF_FFF9);
    send(5'b10100, 3'b000, 32'hFFFF_FFF9, 32'h2);
    wait_valid(lat);
    chk("div_neg", bus.alu_result, 32'hFFFF_FFFD);
`else
    send(5'b10100, 3'b000, 32'd10, 32'd2);
    chk("div_off_valid", 32'(bus.out_valid), 32'd1);
    chk("div_off_result", bus.alu_result, 32'h0);
    chk("div_off_bcond", 32'(bus.alu_bcond), 32'd0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
